// File: rtl/kbd_char_fifo_if.sv
// Keyboard-character FIFO bus: keyboard-handler push side, CPU pop side and status flags.
// master = producer/consumer environment, slave = kbd_char_fifo.
interface kbd_char_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  key_new;
  logic                  key_is_ascii;
  logic [7:0]            key_ascii;
  logic [7:0]            key_scan;
  logic                  key_ctrl;
  logic                  rd_req;
  logic                  clr_overflow;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;

  modport master (
    output key_new, key_is_ascii, key_ascii, key_scan, key_ctrl, rd_req, clr_overflow,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  modport slave (
    input  key_new, key_is_ascii, key_ascii, key_scan, key_ctrl, rd_req, clr_overflow,
    output rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/kbd_char_fifo.sv
// Maps keyboard-handler strobes to terminal characters and buffers them in a circular FIFO.
// Optional feature macro: KBD_CTRLCODE_EN (Ctrl+letter pushes the control code char & 8'h1F).
module kbd_char_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic            clk,
  input logic            clr,
  kbd_char_fifo_if.slave bus
);
  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ZERO   = '0;
  localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,  count_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;

  logic                  char_vld_s;
  logic [7:0]            char_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  push_s;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  // Control keys take precedence over the handler's ASCII output
  always_comb begin
    char_vld_s = 1'b0;
    char_s     = 8'h00;
    if (bus.key_new) begin
      case (bus.key_scan)
        8'h5A:   begin char_vld_s = 1'b1; char_s = 8'h0A; end
        8'h66:   begin char_vld_s = 1'b1; char_s = 8'h08; end
        8'h0D:   begin char_vld_s = 1'b1; char_s = 8'h09; end
        8'h76:   begin char_vld_s = 1'b1; char_s = 8'h1B; end
        default: begin
          if (bus.key_is_ascii) begin
            char_vld_s = 1'b1;
`ifdef KBD_CTRLCODE_EN
            if (bus.key_ctrl && is_letter(bus.key_ascii)) begin
              char_s = bus.key_ascii & 8'h1F;
            end else begin
              char_s = bus.key_ascii;
            end
`else
            char_s = bus.key_ascii;
`endif
          end else begin
            char_vld_s = 1'b0;
          end
        end
      endcase
    end else begin
      char_vld_s = 1'b0;
    end
  end

`ifndef KBD_CTRLCODE_EN
  logic unused_ctrl_s;
  assign unused_ctrl_s = bus.key_ctrl ^ is_letter(bus.key_ascii);
`endif

  assign full_s = (count_q == FULL_COUNT);
  assign pop_s  = bus.rd_req && (count_q != CNT_ZERO);
  // A pop on a full FIFO frees the slot within the same edge
  assign push_s = char_vld_s && (!full_s || pop_s);

  // Next-state for pointers, occupancy, read port and sticky overflow
  always_comb begin
    wr_ptr_d   = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    rd_data_d  = pop_s  ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = pop_s;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (char_vld_s && !push_s) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= char_s;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.empty    = (count_q == CNT_ZERO);
  assign bus.full     = full_s;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_kbd_char_fifo.sv
// Directed self-checking bench for kbd_char_fifo (DEPTH_LOG2 = 4).
module tb_kbd_char_fifo;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;

  kbd_char_fifo_if #(.DEPTH_LOG2(4)) bus ();
  kbd_char_fifo #(.DEPTH_LOG2(4)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_key(input logic asc, input logic [7:0] a, input logic [7:0] s, input logic c);
    bus.key_is_ascii = asc;
    bus.key_ascii    = a;
    bus.key_scan     = s;
    bus.key_ctrl     = c;
    bus.key_new      = 1'b1;
    tick();
    bus.key_new      = 1'b0;
    bus.key_ctrl     = 1'b0;
  endtask

  task automatic pop_once();
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", bus.empty, bus.full); end
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 || bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_rd valid=%b data=%h ovf=%b exp 0/00/0", bus.rd_valid, bus.rd_data, bus.overflow); end
    tick();
    clr = 1'b0;
    push_key(1'b1, 8'h61, 8'h1C, 1'b0);
    checks++; if (bus.count !== 5'd1 || bus.empty !== 1'b0) begin errors++; $display("FAIL t1_push count=%0d empty=%b exp 1/0", bus.count, bus.empty); end
    pop_once();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h61) begin errors++; $display("FAIL t1_pop valid=%b data=%h exp 1/61", bus.rd_valid, bus.rd_data); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL t1_empty got %b exp 1", bus.empty); end
    tick();
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h61) begin errors++; $display("FAIL t1_pulse valid=%b data=%h exp 0/61", bus.rd_valid, bus.rd_data); end
  endtask

  task automatic test_mapping();
    logic [7:0] exp_q [4];
    exp_q = '{8'h0A, 8'h08, 8'h09, 8'h1B};
    push_key(1'b0, 8'h00, 8'h5A, 1'b0);
    push_key(1'b0, 8'h00, 8'h12, 1'b0);
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL t2_shift_nopush count=%0d exp 1", bus.count); end
    push_key(1'b1, 8'h7F, 8'h66, 1'b0);
    push_key(1'b0, 8'h00, 8'h0D, 1'b0);
    push_key(1'b0, 8'h00, 8'h76, 1'b0);
    checks++; if (bus.count !== 5'd4) begin errors++; $display("FAIL t2_count got %0d exp 4", bus.count); end
    for (int i = 0; i < 4; i++) begin
      pop_once();
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_q[i]) begin errors++; $display("FAIL t2_pop%0d valid=%b data=%h exp 1/%h", i, bus.rd_valid, bus.rd_data, exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) begin
      push_key(1'b1, 8'h41 + 8'(i), 8'h00, 1'b0);
      if (i == 15) begin
        checks++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL t3_full16 full=%b ovf=%b exp 1/0", bus.full, bus.overflow); end
      end
    end
    checks++; if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b1) begin errors++; $display("FAIL t3_ovf full=%b count=%0d ovf=%b exp 1/16/1", bus.full, bus.count, bus.overflow); end
    bus.clr_overflow = 1'b1;
    push_key(1'b1, 8'h5A, 8'h00, 1'b0);
    checks++; if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin errors++; $display("FAIL t3_set_wins ovf=%b count=%0d exp 1/16", bus.overflow, bus.count); end
    tick();
    bus.clr_overflow = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL t3_clr_ovf got %b exp 0", bus.overflow); end
    bus.rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h41 + 8'(i)) begin errors++; $display("FAIL t3_pop%0d valid=%b data=%h exp 1/%h", i, bus.rd_valid, bus.rd_data, 8'h41 + 8'(i)); end
    end
    bus.rd_req = 1'b0;
    checks++; if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin errors++; $display("FAIL t3_drained empty=%b count=%0d exp 1/0", bus.empty, bus.count); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push_key(1'b1, 8'h30 + 8'(i), 8'h00, 1'b0);
    bus.rd_req = 1'b1;
    push_key(1'b1, 8'h7A, 8'h00, 1'b0);
    bus.rd_req = 1'b0;
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h30) begin errors++; $display("FAIL t4_oldest valid=%b data=%h exp 1/30", bus.rd_valid, bus.rd_data); end
    checks++; if (bus.count !== 5'd16 || bus.overflow !== 1'b0 || bus.full !== 1'b1) begin errors++; $display("FAIL t4_state count=%0d ovf=%b full=%b exp 16/0/1", bus.count, bus.overflow, bus.full); end
    for (int i = 1; i < 17; i++) begin
      pop_once();
      checks++; if (bus.rd_data !== ((i == 16) ? 8'h7A : 8'h30 + 8'(i))) begin errors++; $display("FAIL t4_drain%0d got %h", i, bus.rd_data); end
    end
  endtask

  task automatic test_empty_and_clr();
    pop_once();
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h7A || bus.count !== 5'd0) begin errors++; $display("FAIL t5_empty_pop valid=%b data=%h count=%0d exp 0/7a/0", bus.rd_valid, bus.rd_data, bus.count); end
    bus.rd_req = 1'b1;
    push_key(1'b1, 8'h55, 8'h00, 1'b0);
    bus.rd_req = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0 || bus.count !== 5'd1) begin errors++; $display("FAIL t5_push_on_empty valid=%b count=%0d exp 0/1", bus.rd_valid, bus.count); end
    bus.rd_req = 1'b1;
    #2 clr = 1'b1;
    #1;
    checks++; if (bus.rd_valid !== 1'b0 || bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin errors++; $display("FAIL t5_clr valid=%b empty=%b data=%h exp 0/1/00", bus.rd_valid, bus.empty, bus.rd_data); end
    tick();
    clr = 1'b0;
    bus.rd_req = 1'b0;
    tick();
    checks++; if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0) begin errors++; $display("FAIL t5_after_clr valid=%b count=%0d exp 0/0", bus.rd_valid, bus.count); end
  endtask

  task automatic test_ctrl();
    logic [7:0] exp_c;
`ifdef KBD_CTRLCODE_EN
    exp_c = 8'h03;
`else
    exp_c = 8'h63;
`endif
    push_key(1'b1, 8'h63, 8'h21, 1'b1);
    push_key(1'b1, 8'h31, 8'h16, 1'b1);
    push_key(1'b0, 8'h00, 8'h5A, 1'b1);
    pop_once();
    checks++; if (bus.rd_data !== exp_c) begin errors++; $display("FAIL t6_ctrl_c got %h exp %h", bus.rd_data, exp_c); end
    pop_once();
    checks++; if (bus.rd_data !== 8'h31) begin errors++; $display("FAIL t6_ctrl_digit got %h exp 31", bus.rd_data); end
    pop_once();
    checks++; if (bus.rd_data !== 8'h0A || bus.empty !== 1'b1) begin errors++; $display("FAIL t6_ctrl_enter data=%h empty=%b exp 0a/1", bus.rd_data, bus.empty); end
  endtask

  initial begin
    bus.key_new = 1'b0; bus.key_is_ascii = 1'b0; bus.key_ascii = 8'h00; bus.key_scan = 8'h00;
    bus.key_ctrl = 1'b0; bus.rd_req = 1'b0; bus.clr_overflow = 1'b0;
    test_reset();
    test_mapping();
    test_overflow();
    test_full_push_pop();
    test_empty_and_clr();
    test_ctrl();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
